// File: rtl/latency_stats.sv
// Reaction-time meter: counts prescaled ticks from start to sensor_trigger, keeps min/max/windowed average.
// Capture lands one cycle after the trigger; no backpressure, all inputs and outputs are single-cycle pulses or levels.
module latency_stats #(
  parameter int CLOCK_DIVIDER = 27,
  parameter int COUNT_WIDTH   = 20,
  parameter int AVERAGE_BITS  = 4,
  parameter int WINDOW_MINMAX = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sensor_trigger,
  input  logic                   clear_stats,
  output logic [COUNT_WIDTH-1:0] current,
  output logic [COUNT_WIDTH-1:0] minimum,
  output logic [COUNT_WIDTH-1:0] maximum,
  output logic [COUNT_WIDTH-1:0] average,
  output logic                   sample_valid,
  output logic                   average_valid,
  output logic                   timeout,
  output logic                   armed
);

  localparam int PRE_W = $clog2(CLOCK_DIVIDER);
  localparam int ACC_W = COUNT_WIDTH + AVERAGE_BITS;
  localparam logic [COUNT_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [COUNT_WIDTH-1:0] SAT_PREV = ALL_ONES - COUNT_WIDTH'(1);
  localparam logic [PRE_W-1:0]       PRE_LAST = PRE_W'(CLOCK_DIVIDER - 1);
  localparam logic [AVERAGE_BITS-1:0] WIN_LAST = '1;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t                  state, next_state;
  logic [PRE_W-1:0]        prescaler;
  logic [COUNT_WIDTH-1:0]  elapsed;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        sum;
  logic [AVERAGE_BITS-1:0] win_cnt;
  logic                    have_sample;
  logic                    tick, capture, saturate, accept, load_minmax;

  assign tick     = (prescaler == PRE_LAST);
  assign capture  = (state == ARMED) && sensor_trigger;
  // A trigger on the same edge as saturation still wins and is measured.
  assign saturate = (state == ARMED) && !sensor_trigger && tick && (elapsed == SAT_PREV);
  assign accept   = capture && !clear_stats;
  assign sum      = acc + ACC_W'(elapsed);
  assign load_minmax = !have_sample || ((WINDOW_MINMAX != 0) && (win_cnt == '0));
  assign armed    = (state == ARMED);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (capture || saturate) next_state = IDLE;
    if (start)               next_state = ARMED;
  end

  always_ff @(posedge clock) begin
    if (reset || start) begin
      prescaler <= '0;
      elapsed   <= '0;
    end else if (state == ARMED) begin
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      if (tick) elapsed <= elapsed + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      current      <= ALL_ONES;
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      sample_valid <= capture;
      if (capture)       current <= elapsed;
      else if (saturate) current <= ALL_ONES;
      if (start)         timeout <= 1'b0;
      else if (saturate) timeout <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear_stats) begin
      minimum       <= ALL_ONES;
      maximum       <= '0;
      average       <= '0;
      average_valid <= 1'b0;
      acc           <= '0;
      win_cnt       <= '0;
      have_sample   <= 1'b0;
    end else if (accept) begin
      have_sample <= 1'b1;
      if (load_minmax || elapsed < minimum) minimum <= elapsed;
      if (load_minmax || elapsed > maximum) maximum <= elapsed;
      // Final sample of the window: publish the mean and start a fresh window.
      if (win_cnt == WIN_LAST) begin
        average       <= sum[ACC_W-1:AVERAGE_BITS];
        average_valid <= 1'b1;
        acc           <= '0;
        win_cnt       <= '0;
      end else begin
        acc     <= sum;
        win_cnt <= win_cnt + AVERAGE_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_latency_stats.sv
// Directed and randomized checks of latency_stats against a cycle-count reference model.
module tb_latency_stats;

  localparam int D = 4;
  localparam int W = 8;
  localparam int A = 2;
  localparam int SAT = (1 << W) - 1;

  logic       clock = 1'b0;
  logic       reset, start, sensor_trigger, clear_stats;
  logic [W-1:0] current, minimum, maximum, average;
  logic       sample_valid, average_valid, timeout, armed;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cyc = 0, m_start = 0;
  int m_cur, m_min, m_max, m_avg;
  bit m_sv, m_avgv, m_to, m_armed;
  int m_win[$];

  latency_stats #(
    .CLOCK_DIVIDER(D), .COUNT_WIDTH(W), .AVERAGE_BITS(A), .WINDOW_MINMAX(1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .sensor_trigger(sensor_trigger),
    .clear_stats(clear_stats), .current(current), .minimum(minimum), .maximum(maximum),
    .average(average), .sample_valid(sample_valid), .average_valid(average_valid),
    .timeout(timeout), .armed(armed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model_stats();
    m_min = SAT; m_max = 0; m_avg = 0; m_avgv = 0;
    m_win.delete();
  endtask

  task automatic add_sample(input int s);
    int sum;
    m_win.push_back(s);
    m_min = SAT; m_max = 0; sum = 0;
    foreach (m_win[i]) begin
      if (m_win[i] < m_min) m_min = m_win[i];
      if (m_win[i] > m_max) m_max = m_win[i];
      sum += m_win[i];
    end
    if (m_win.size() == (1 << A)) begin
      m_avg  = sum / (1 << A);
      m_avgv = 1;
      m_win.delete();
    end
  endtask

  task automatic model_edge(input bit st, input bit tr, input bit cl, input bit rs);
    int k;
    m_cyc++;
    m_sv = 0;
    if (rs) begin
      m_cur = SAT; m_to = 0; m_armed = 0;
      clear_model_stats();
      return;
    end
    if (m_armed) begin
      k = m_cyc - m_start;
      if (tr) begin
        m_cur = (k - 1) / D; m_sv = 1; m_armed = 0;
        if (!cl) add_sample(m_cur);
      end else if (k == SAT * D) begin
        m_cur = SAT; m_to = 1; m_armed = 0;
      end
    end
    if (st) begin
      m_armed = 1; m_start = m_cyc; m_to = 0;
    end
    if (cl) clear_model_stats();
  endtask

  task automatic check_all();
    chk("current", current, m_cur);
    chk("sample_valid", sample_valid, m_sv);
    chk("minimum", minimum, m_min);
    chk("maximum", maximum, m_max);
    chk("average", average, m_avg);
    chk("average_valid", average_valid, m_avgv);
    chk("timeout", timeout, m_to);
    chk("armed", armed, m_armed);
  endtask

  task automatic step(input bit st, input bit tr, input bit cl, input bit rs);
    start = st; sensor_trigger = tr; clear_stats = cl; reset = rs;
    @(posedge clock);
    model_edge(st, tr, cl, rs);
    #1;
    check_all();
    start = 0; sensor_trigger = 0; clear_stats = 0; reset = 0;
  endtask

  // Arm, then trigger so the captured value is v ticks.
  task automatic measure(input int v);
    step(1, 0, 0, 0);
    repeat (4 * v) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
  endtask

  initial begin
    int waited;
    bit saw_sv;
    start = 0; sensor_trigger = 0; clear_stats = 0; reset = 1;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_current", current, 255);
    chk("reset_minimum", minimum, 255);

    // first measurement: trigger at cycle 41
    measure(10);
    chk("r029_current", current, 10);
    chk("r029_sample_valid", sample_valid, 1);
    chk("r029_min", minimum, 10);
    chk("r029_max", maximum, 10);
    chk("r029_armed", armed, 0);

    // one full window
    step(0, 0, 1, 0);
    measure(10); measure(20); measure(30); measure(41);
    chk("r030_average", average, 25);
    chk("r030_average_valid", average_valid, 1);
    chk("r030_min", minimum, 10);
    chk("r030_max", maximum, 41);
    measure(7);
    chk("r030_min_new_window", minimum, 7);
    chk("r030_max_new_window", maximum, 7);
    chk("r030_average_held", average, 25);

    // saturation with no trigger
    step(1, 0, 0, 0);
    waited = 0; saw_sv = 0;
    while (!timeout && waited < 1100) begin
      step(0, 0, 0, 0);
      if (sample_valid) saw_sv = 1;
      waited++;
    end
    chk("r031_timeout", timeout, 1);
    chk("r031_current", current, 255);
    chk("r031_no_sample_valid", saw_sv, 0);
    chk("r031_avg_kept", average, 25);

    // trigger while idle, then trigger with clear
    step(0, 1, 0, 0);
    chk("r032_idle_current", current, 255);
    step(1, 0, 0, 0);
    repeat (12) step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("r032_current", current, 3);
    chk("r032_min", minimum, 255);
    chk("r032_max", maximum, 0);
    chk("r032_average_valid", average_valid, 0);

    // start and trigger together while armed
    step(1, 0, 0, 0);
    repeat (19) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("r033_current", current, 4);
    chk("r033_armed", armed, 1);
    repeat (12) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("r033_second", current, 3);

    // reset mid-measurement
    step(1, 0, 0, 0);
    repeat (19) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("r034_armed", armed, 0);
    chk("r034_current", current, 255);
    step(0, 1, 0, 0);
    chk("r034_ignored_sv", sample_valid, 0);

    // randomized pulses
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/latency_stats.md
LATENCY_STATS -- requirements
Module: latency_stats

Interface
REQ-001 SHALL have parameter CLOCK_DIVIDER, default 27: clock cycles per elapsed-time tick (1 us at 27 MHz); legal range ≥2.
REQ-002 SHALL have parameter COUNT_WIDTH, default 20: width of elapsed count and of all result outputs.
REQ-003 SHALL have parameter AVERAGE_BITS, default 4: averaging window is 2^AVERAGE_BITS accepted samples.
REQ-004 SHALL have parameter WINDOW_MINMAX, default 1: 1 = min/max restart each window; 0 = min/max cumulative since last clear.
REQ-005 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: one-cycle pulse, arms a new measurement (flash emitted).
REQ-008 SHALL have port sensor_trigger, input, 1: one-cycle pulse, sensor rising edge detected.
REQ-009 SHALL have port clear_stats, input, 1: one-cycle pulse, discards all statistics.
REQ-010 SHALL have port current, output, COUNT_WIDTH: last captured elapsed count (binary ticks).
REQ-011 SHALL have ports minimum, maximum, average, output, COUNT_WIDTH each: statistics (binary ticks).
REQ-012 SHALL have port sample_valid, output, 1: one-cycle pulse when current is updated.
REQ-013 SHALL have port average_valid, output, 1: level; high once at least one window has completed since reset/clear.
REQ-014 SHALL have port timeout, output, 1: level; high if the last measurement saturated.
REQ-015 SHALL have port armed, output, 1: high while in state ARMED.

Function
REQ-016 SHALL implement states IDLE and ARMED; start in any state -> ARMED with prescaler = 0, elapsed = 0, timeout cleared.
REQ-017 In ARMED, SHALL increment prescaler each cycle; at prescaler == CLOCK_DIVIDER-1, prescaler -> 0 and elapsed += 1.
REQ-018 With start sampled in cycle 0, sensor_trigger sampled in ARMED in cycle n ≥ 1 SHALL capture floor((n-1)/CLOCK_DIVIDER) into current at cycle n+1, pulse sample_valid at n+1, and return to IDLE.
REQ-019 sensor_trigger in IDLE SHALL be ignored: no output change.
REQ-020 When elapsed reaches 2^COUNT_WIDTH-1, SHALL set current to all-ones, set timeout, return to IDLE, not pulse sample_valid, and not update statistics.
REQ-021 Simultaneous start and sensor_trigger in ARMED SHALL capture the sample per REQ-018, then re-arm per REQ-016.
REQ-022 Each accepted sample SHALL add to a COUNT_WIDTH+AVERAGE_BITS-bit accumulator, with no overflow possible, and increment a window counter.
REQ-023 On the 2^AVERAGE_BITS-th sample of a window, SHALL write average = (accumulator + sample) >> AVERAGE_BITS in the same cycle as current, set average_valid, and clear the accumulator and window counter.
REQ-024 Min/max SHALL update in the same cycle as current; first sample after reset/clear, or, when WINDOW_MINMAX = 1, first sample of each window, SHALL load both min and max.
REQ-025 clear_stats SHALL reset minimum to all-ones, maximum, average, accumulator and window counter to 0, and clear average_valid; it SHALL not affect state, current or timeout.
REQ-026 clear_stats coincident with a capture SHALL take priority: current updates and sample_valid pulses, but the sample does not enter the statistics.

Reset
REQ-027 reset SHALL have priority over all inputs and SHALL force state IDLE, prescaler/elapsed 0, current and minimum all-ones, maximum and average 0, accumulator and window counter 0, and sample_valid, average_valid, timeout and armed all 0.
REQ-028 reset asserted mid-measurement SHALL abandon it; no sample_valid SHALL follow.

Verification (CLOCK_DIVIDER=4, COUNT_WIDTH=8, AVERAGE_BITS=2, WINDOW_MINMAX=1)
REQ-029 start at cycle 0, sensor_trigger at cycle 41 -> current=10, sample_valid at cycle 42, minimum=maximum=10, armed=0.
REQ-030 four samples 10,20,30,41 -> average=25 after the fourth, average_valid=1, minimum=10, maximum=41; fifth sample 7 -> minimum=maximum=7, average still 25.
REQ-031 start with no trigger -> at elapsed 255: current=255, timeout=1, no sample_valid, statistics unchanged.
REQ-032 sensor_trigger while IDLE and sensor_trigger with clear_stats -> first gives no change; second gives current updated, minimum=255, maximum=0, average_valid=0.
REQ-033 start and sensor_trigger in the same cycle while ARMED -> sample captured, armed stays 1, next capture counts from the new start.
REQ-034 reset asserted at cycle 20 of a measurement -> all outputs at reset values at cycle 21; later trigger without start is ignored.
